// File: rtl/moore_seq_detector_param.sv
// rtl/moore_seq_detector_param.sv - parameterized Moore serial pattern detector
// Optional saturating match counter is built only when SEQDET_MATCH_COUNT_EN is defined.

module moore_seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap_en,
    output logic             detect,
    output logic [CNT_W-1:0] match_count
);

    localparam int SW = $clog2(PAT_LEN + 1);

    typedef enum logic [SW-1:0] {
        S0     = '0,
        SMATCH = SW'(PAT_LEN)
    } state_t;

    state_t state;
    state_t state_nxt;

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
    function automatic int calc_next(input int k, input logic b);
        logic [PAT_LEN:0] hist;
        logic             ok;
        int               best;
        hist = '0;
        for (int i = 0; i < PAT_LEN; i++)
            if (i < k) hist[i] = PATTERN[PAT_LEN-1-i];
        hist[k] = b;
        best = 0;
        for (int j = 1; j <= PAT_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int m = 0; m < PAT_LEN; m++) begin
                    if (m < j) begin
                        if (hist[k+1-j+m] != PATTERN[PAT_LEN-1-m]) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    logic [SW-1:0] nxt_tbl [PAT_LEN+1][2];

    for (genvar k = 0; k <= PAT_LEN; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int NXT = calc_next(k, 1'(b));
            assign nxt_tbl[k][b] = SW'(NXT);
        end
    end

    always_comb begin
        state_nxt = state;
        if (din_valid) begin
            // Non-overlapping mode restarts from the incoming bit alone.
            if (state == SMATCH && !overlap_en)
                state_nxt = (din == PATTERN[PAT_LEN-1]) ? state_t'(SW'(1)) : S0;
            else
                state_nxt = state_t'(nxt_tbl[state][din]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S0;
        else
            state <= state_nxt;
    end

    assign detect = (state == SMATCH);

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (din_valid && state_nxt == SMATCH && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// tb/tb_moore_seq_detector_param.sv - self-checking bench for moore_seq_detector_param
// Expected counts follow SEQDET_MATCH_COUNT_EN (zero when the counter is not built).

module tb_moore_seq_detector_param;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       din        = 1'b0;
    logic       din_valid  = 1'b0;
    logic       overlap_en = 1'b0;
    logic       det4, det2, det3;
    logic [7:0] cnt4;
    logic [1:0] cnt2;
    logic [7:0] cnt3;

    always #5 clk = ~clk;

    moore_seq_detector_param u4 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .overlap_en(overlap_en), .detect(det4), .match_count(cnt4)
    );

    moore_seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .overlap_en(overlap_en), .detect(det2), .match_count(cnt2)
    );

    moore_seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(8)) u3 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .overlap_en(overlap_en), .detect(det3), .match_count(cnt3)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic rst;
        logic d;
        logic v;
        logic o;
        logic det;
        int   cnt;
    } vec_t;

    vec_t tbl [64];
    int   nv = 0;

    // Reference: bit history since the last discard; matched when its tail equals the pattern.
    localparam int MPAT  [3] = '{11, 11, 7};
    localparam int MPLEN [3] = '{4, 4, 3};
    localparam int MMAX  [3] = '{255, 3, 255};
    logic [31:0] m_bits [3];
    int          m_len  [3];
    logic        m_det  [3];
    int          m_cnt  [3];

    function automatic int ec(input int c);
`ifdef SEQDET_MATCH_COUNT_EN
        return c;
`else
        return (c == 0) ? 0 : 0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_bits[i] = '0;
            m_len[i]  = 0;
            m_det[i]  = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_bit(input logic d, input logic o);
        logic [31:0] mask;
        for (int i = 0; i < 3; i++) begin
            if (m_det[i] && !o) begin
                m_bits[i] = '0;
                m_len[i]  = 0;
            end
            m_bits[i] = {m_bits[i][30:0], d};
            if (m_len[i] < 32) m_len[i]++;
            mask = (32'd1 << MPLEN[i]) - 32'd1;
            m_det[i] = (m_len[i] >= MPLEN[i]) && ((m_bits[i] & mask) == 32'(MPAT[i]));
            if (m_det[i] && m_cnt[i] < MMAX[i]) m_cnt[i]++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic d, input logic v, input logic o);
        din        = d;
        din_valid  = v;
        overlap_en = o;
        @(posedge clk);
        if (v) model_bit(d, o);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_det4", det4, 0);
        chk("rst_cnt4", cnt4, 0);
        chk("rst_det3", det3, 0);
        chk("rst_cnt2", cnt2, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic addv(input logic r, input logic d, input logic v, input logic o,
                        input logic det, input int c);
        tbl[nv] = '{r, d, v, o, det, c};
        nv++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] sat;
        int          pulses;
        logic        d, v, o;

        // Overlap mode: 1011011 -> matches after bits 4 and 7
        addv(1, 1, 1, 1, 0, 0); addv(0, 0, 1, 1, 0, 0); addv(0, 1, 1, 1, 0, 0);
        addv(0, 1, 1, 1, 1, 1); addv(0, 0, 1, 1, 0, 1); addv(0, 1, 1, 1, 0, 1);
        addv(0, 1, 1, 1, 1, 2);
        // Non-overlap: same stream, then 0,1,1 proves the final state was S1
        addv(1, 1, 1, 0, 0, 0); addv(0, 0, 1, 0, 0, 0); addv(0, 1, 1, 0, 0, 0);
        addv(0, 1, 1, 0, 1, 1); addv(0, 0, 1, 0, 0, 1); addv(0, 1, 1, 0, 0, 1);
        addv(0, 1, 1, 0, 0, 1); addv(0, 0, 1, 0, 0, 1); addv(0, 1, 1, 0, 0, 1);
        addv(0, 1, 1, 0, 1, 2);
        // Valid gaps with toggling din, then hold while matched
        addv(1, 1, 1, 1, 0, 0); addv(0, 0, 1, 1, 0, 0); addv(0, 1, 1, 1, 0, 0);
        addv(0, 0, 0, 1, 0, 0); addv(0, 1, 0, 1, 0, 0); addv(0, 0, 0, 1, 0, 0);
        addv(0, 1, 1, 1, 1, 1); addv(0, 1, 0, 1, 1, 1); addv(0, 0, 0, 1, 1, 1);
        addv(0, 0, 1, 1, 0, 1);

        #2;
        model_clear();
        do_reset();

        for (int i = 0; i < nv; i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].d, tbl[i].v, tbl[i].o);
            chk($sformatf("tbl%0d_det", i), det4, tbl[i].det);
            chk($sformatf("tbl%0d_cnt", i), cnt4, ec(tbl[i].cnt));
        end

        // Reset mid-pattern discards partial match; first edge after release samples
        do_reset();
        step(1, 1, 1); step(0, 1, 1); step(1, 1, 1); step(1, 1, 1);
        chk("mid_pre_det", det4, 1);
        step(0, 1, 1); step(1, 1, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_det", det4, 0);
        chk("mid_rst_cnt", cnt4, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_det", det4, 0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        step(1, 1, 1);
        chk("mid_post_no_det", det4, 0);
        step(0, 1, 1); step(1, 1, 1); step(1, 1, 1);
        chk("mid_post_det", det4, 1);
        chk("mid_post_cnt", cnt4, ec(1));

        // Saturation: five overlapping matches into a 2-bit counter
        do_reset();
        sat    = 16'b1011011011011011;
        pulses = 0;
        for (int i = 15; i >= 0; i--) begin
            step(sat[i], 1, 1);
            if (det2) pulses++;
        end
        chk("sat_pulses", pulses, 5);
        chk("sat_cnt2", cnt2, ec(3));
        chk("sat_cnt4", cnt4, ec(5));

        // Periodic 111 pattern, overlapping then non-overlapping
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1);
            chk($sformatf("per_ovl_det%0d", i), det3, (i >= 2) ? 1 : 0);
        end
        chk("per_ovl_cnt", cnt3, ec(4));
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0);
            chk($sformatf("per_non_det%0d", i), det3, (i == 2 || i == 5) ? 1 : 0);
        end
        chk("per_non_cnt", cnt3, ec(2));

        // Randomized stream against the reference model
        do_reset();
        o = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            d = 1'($urandom);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) o = ~o;
            step(d, v, o);
            chk("rnd_det4", det4, m_det[0]);
            chk("rnd_det2", det2, m_det[1]);
            chk("rnd_det3", det3, m_det[2]);
            chk("rnd_cnt4", cnt4, ec(m_cnt[0]));
            chk("rnd_cnt2", cnt2, ec(m_cnt[1]));
            chk("rnd_cnt3", cnt3, ec(m_cnt[2]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector_param.md
MOORE_SEQ_DETECTOR_PARAM -- requirements
Module: moore_seq_detector_param

Interface
REQ-001 SHALL provide parameter PAT_LEN, default 4, meaning the pattern length in bits; legal range 2..16.
REQ-002 SHALL provide parameter PATTERN, default 4'b1011, width PAT_LEN; PATTERN[PAT_LEN-1] is the first bit expected on the line.
REQ-003 SHALL provide parameter CNT_W, default 8, meaning the width of the match counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port din, input, 1 bit: serial data bit.
REQ-007 SHALL have port din_valid, input, 1 bit: din is sampled only when din_valid is high.
REQ-008 SHALL have port overlap_en, input, 1 bit: 1 selects overlapping detection and 0 selects non-overlapping detection; it is sampled on every valid bit.
REQ-009 SHALL have port detect, output, 1 bit: a registered Moore output, high while the FSM is in the match state.
REQ-010 SHALL have port match_count, output, CNT_W bits: the number of matches detected since reset.

Function
REQ-011 SHALL implement a Moore FSM with states S0..S(PAT_LEN), where Sk means the last k sampled bits equal the first k pattern bits.
REQ-012 SHALL drive detect high only in state S(PAT_LEN) and as a pure function of the state register, with no combinational path from din.
REQ-013 SHALL hold the state unchanged on any cycle where din_valid is low, so detect and match_count also hold.
REQ-014 SHALL compute the next state, when in Sk with k below PAT_LEN and valid bit b, as the largest j no greater than k+1 such that the last j bits of the received history (the first k pattern bits followed by b) equal the first j pattern bits.
REQ-015 SHALL, when in S(PAT_LEN) with overlap_en high, compute the next state as in REQ-014, using the full pattern followed by b as the history.
REQ-016 SHALL, when in S(PAT_LEN) with overlap_en low, discard the history: the next state is S1 if b equals PATTERN[PAT_LEN-1], otherwise S0.
REQ-017 SHALL raise detect during the clock cycle immediately after the rising edge that samples the final pattern bit, giving a latency of 1 cycle.
REQ-018 SHALL increment match_count by 1 on every transition into S(PAT_LEN), including the S(PAT_LEN) to S(PAT_LEN) transition that occurs in overlap mode for periodic patterns.
REQ-019 SHALL saturate match_count at all-ones, with no wrap-around.
REQ-020 SHALL derive all transition logic from PATTERN and PAT_LEN at elaboration time, with no per-pattern hand coding.

Reset
REQ-021 SHALL, while reset is low, force the state to S0, detect to 0 and match_count to 0, independent of clk.
REQ-022 SHALL, when reset is asserted mid-pattern, discard any partial match; after reset deasserts, a complete new pattern is required before detect goes high.
REQ-023 SHALL treat the first rising clk edge after reset deassertion as a normal sampling edge.

Configuration
REQ-024 SHALL use macro SEQDET_MATCH_COUNT_EN: when it is defined, the match_count counter is implemented as in REQ-018 and REQ-019; when it is undefined, match_count is tied to 0, no counter flops are synthesized, and detect behaviour is identical.

Verification
REQ-025 SHALL verify overlap mode: defaults, overlap_en=1, din_valid=1, bits 1,0,1,1,0,1,1 -> detect high after bit 4 and after bit 7, match_count=2.
REQ-026 SHALL verify non-overlap mode: the same stream with overlap_en=0 -> detect high only after bit 4, match_count=1, final state S1.
REQ-027 SHALL verify valid gaps: bits 1,0,1 with din_valid=1, then 3 cycles with din_valid=0 and din toggling, then bit 1 -> a single detect 1 cycle after the last valid bit.
REQ-028 SHALL verify reset mid-pattern: bits 1,0,1, then reset low for 1 cycle, then bit 1 -> no detect, and detect and match_count are 0 during reset.
REQ-029 SHALL verify saturation: CNT_W=2 with 5 overlapping matches of 1011 -> match_count stops at 3 while detect still pulses 5 times.
REQ-030 SHALL verify the periodic pattern: PAT_LEN=3, PATTERN=3'b111, overlap_en=1, six 1s -> detect high for 4 consecutive cycles and match_count=4; the same stimulus with overlap_en=0 -> match_count=2.
